up_mem_ctrl: RTL and testbench

//  Controller that shares the single-port up memory (async read, sync write) between the up core and a serial

---
 rtl/up_mem_ctrl_pkg.sv | 20 ++
 rtl/up_mem_ctrl_timeout.sv | 36 +++
 rtl/up_mem_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_up_mem_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/up_mem_ctrl_pkg.sv
// up_mem_ctrl shared definitions: FSM state codes,
// serial command bytes and response bytes.
package up_mem_ctrl_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_ACCESS = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;
  localparam logic [2:0] S_TXWAIT = 3'd5;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_H = 8'h48;
  localparam logic [7:0] CMD_G = 8'h47;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

endpackage

// File: rtl/up_mem_ctrl_timeout.sv
// up_mem_ctrl inter-byte timeout counter:
// clear wins over enable, expire on the last counted cycle.
module up_mem_ctrl_timeout #(
  parameter int TO_CYCLES = 50000,
  parameter int TO_W      = 16
) (
  input  logic clk,
  input  logic nRst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  // next count: restart on clear, step while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + 1'b1;
  end

  // count register
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expire_o = en_i & !clr_i &
    (cnt_q == TO_W'(TO_CYCLES - 1));

endmodule

// File: rtl/up_mem_ctrl.sv
// up_mem_ctrl: shares up memory between core and serial.
// Optional halt commands under `UP_MEM_CTRL_HALT_EN.
module up_mem_ctrl
  import up_mem_ctrl_pkg::*;
#(
  parameter int TO_CYCLES = 50000,
  parameter int TO_W      = 16
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_gnt,
  output logic [7:0] cpu_rdata,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata,
  output logic       err
);

  logic [2:0] state_q, state_d;
  logic       is_wr_q, is_wr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_start_q, tx_start_d;
  logic       err_q, err_d;
  logic       halt;
  logic       in_arg;
  logic       to_exp;
  logic       serial_own;

`ifdef UP_MEM_CTRL_HALT_EN
  logic halt_q, halt_d;
  assign halt = halt_q;
`else
  assign halt = 1'b0;
`endif

  assign in_arg = (state_q == S_ADDR) |
                  (state_q == S_DATA);

  up_mem_ctrl_timeout #(
    .TO_CYCLES (TO_CYCLES),
    .TO_W      (TO_W)
  ) u_to (
    .clk      (clk),
    .nRst     (nRst),
    .clr_i    (!in_arg | rx_valid),
    .en_i     (in_arg),
    .expire_o (to_exp)
  );

  // command FSM next-state and datapath register updates
  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    err_d      = err_q;
`ifdef UP_MEM_CTRL_HALT_EN
    halt_d     = halt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_W ||
              rx_data == CMD_R) begin
            is_wr_d = (rx_data == CMD_W);
            state_d = S_ADDR;
`ifdef UP_MEM_CTRL_HALT_EN
          end else if (rx_data == CMD_H) begin
            halt_d    = 1'b1;
            tx_data_d = ACK;
            state_d   = S_RESP;
          end else if (rx_data == CMD_G) begin
            halt_d    = 1'b0;
            tx_data_d = ACK;
            state_d   = S_RESP;
`endif
          end else begin
            tx_data_d = NAK;
            err_d     = 1'b1;
            state_d   = S_RESP;
          end
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          addr_d  = rx_data;
          state_d = is_wr_q ? S_DATA : S_ACCESS;
        end else if (to_exp) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          data_d  = rx_data;
          state_d = S_ACCESS;
        end else if (to_exp) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        tx_data_d = is_wr_q ? ACK : mem_rdata;
        state_d   = S_RESP;
      end
      S_RESP: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = S_TXWAIT;
        end
      end
      S_TXWAIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // a byte arriving while a command is being served is lost
    if (rx_valid && !in_arg && state_q != S_IDLE)
      err_d = 1'b1;
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= S_IDLE;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      err_q      <= err_d;
    end
  end

`ifdef UP_MEM_CTRL_HALT_EN
  // core halt flag, survives across commands
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)
      halt_q <= 1'b0;
    else
      halt_q <= halt_d;
  end
`endif

  // memory port mux: serial owns the port only in ACCESS
  assign serial_own = (state_q == S_ACCESS);
  assign cpu_gnt    = cpu_req & !serial_own & !halt;
  assign cpu_rdata  = mem_rdata;

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = cpu_req & cpu_we & cpu_gnt;
    if (serial_own) begin
      mem_addr  = addr_q;
      mem_wdata = data_q;
      mem_we    = is_wr_q;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign err      = err_q;

endmodule

// File: tb/tb_up_mem_ctrl.sv
// tb_up_mem_ctrl: directed serial/core vectors for up_mem_ctrl
// with a behavioural async-read sync-write memory.
module tb_up_mem_ctrl;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       cpu_req = 1'b0;
  logic       cpu_we = 1'b0;
  logic [7:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic       cpu_gnt;
  logic [7:0] cpu_rdata;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       tx_busy = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic       err;

  logic [7:0] mem [256];
  int         we_cnt = 0;
  int         tx_cnt = 0;
  logic [7:0] we_addr = '0;
  logic [7:0] we_data = '0;
  logic [7:0] tx_last = '0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         b_we, b_tx;

  always #5 clk = ~clk;

  up_mem_ctrl #(
    .TO_CYCLES (8),
    .TO_W      (4)
  ) dut (
    .clk       (clk),
    .nRst      (nRst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rdata (cpu_rdata),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .err       (err)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_cnt  <= we_cnt + 1;
      we_addr <= mem_addr;
      we_data <= mem_wdata;
    end
    if (tx_start) begin
      tx_cnt  <= tx_cnt + 1;
      tx_last <= tx_data;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // drive one rx pulse; returns at the negedge after capture
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // bounded wait for one more tx_start than base
  task automatic wait_tx(input string tag, input int base);
    for (int i = 0; i < 30 && tx_cnt == base; i++)
      @(negedge clk);
    chk(tag, tx_cnt - base, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nRst = 1'b0;
    cyc(2);
    nRst = 1'b1;
    cyc(1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    cyc(2);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_err", err, 0);
    chk("rst_mem_we", mem_we, 0);
    nRst = 1'b1;
    cyc(1);

    // serial write 57,10,A5
    b_we = we_cnt; b_tx = tx_cnt;
    send(8'h57); send(8'h10); send(8'hA5);
    chk("w_access_we", mem_we, 1);
    chk("w_access_addr", mem_addr, 8'h10);
    chk("w_access_data", mem_wdata, 8'hA5);
    chk("w_tx_early", tx_cnt - b_tx, 0);
    wait_tx("w_tx_seen", b_tx);
    chk("w_we_count", we_cnt - b_we, 1);
    chk("w_we_addr", we_addr, 8'h10);
    chk("w_we_data", we_data, 8'hA5);
    chk("w_ack", tx_last, 8'h06);
    chk("w_mem", mem[8'h10], 8'hA5);
    cyc(2);

    // serial read back 52,10
    b_tx = tx_cnt; b_we = we_cnt;
    send(8'h52); send(8'h10);
    chk("r_no_we", mem_we, 0);
    wait_tx("r_tx_seen", b_tx);
    chk("r_data", tx_last, 8'hA5);
    chk("r_we_none", we_cnt - b_we, 0);
    chk("r_err", err, 0);
    cyc(3);
    chk("r_tx_once", tx_cnt - b_tx, 1);

    // core read path follows mem_rdata
    cpu_addr = 8'h10;
    #1 chk("cpu_rdata", cpu_rdata, 8'hA5);

    // contention: core write raised during serial ACCESS
    b_tx = tx_cnt;
    send(8'h57); send(8'h30); send(8'h77);
    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 8'h20; cpu_wdata = 8'h3C;
    #1;
    chk("c_gnt_access", cpu_gnt, 0);
    chk("c_serial_addr", mem_addr, 8'h30);
    chk("c_serial_we", mem_we, 1);
    @(negedge clk);
    chk("c_gnt_next", cpu_gnt, 1);
    chk("c_cpu_addr", mem_addr, 8'h20);
    chk("c_cpu_we", mem_we, 1);
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0;
    chk("c_mem30", mem[8'h30], 8'h77);
    chk("c_mem20", mem[8'h20], 8'h3C);
    wait_tx("c_tx_seen", b_tx);
    chk("c_ack", tx_last, 8'h06);
    cyc(2);

    // serial read of core-written location
    b_tx = tx_cnt;
    send(8'h52); send(8'h20);
    wait_tx("r2_tx_seen", b_tx);
    chk("r2_data", tx_last, 8'h3C);
    chk("r2_err", err, 0);
    cyc(2);

    // timeout: 57,10 then silence
    b_we = we_cnt; b_tx = tx_cnt;
    send(8'h57); send(8'h10);
    cyc(7);
    chk("to_err_early", err, 0);
    cyc(1);
    chk("to_err", err, 1);
    cyc(6);
    chk("to_no_we", we_cnt - b_we, 0);
    chk("to_no_tx", tx_cnt - b_tx, 0);
    chk("to_mem_kept", mem[8'h10], 8'hA5);

    // reset clears err and discards a partial write
    do_reset();
    chk("rst2_err", err, 0);
    b_we = we_cnt; b_tx = tx_cnt;
    send(8'h57); send(8'h40);
    do_reset();
    cyc(12);
    chk("mid_no_we", we_cnt - b_we, 0);
    chk("mid_no_tx", tx_cnt - b_tx, 0);
    chk("mid_err", err, 0);
    chk("mid_mem", mem[8'h40], 8'h00);

    // bad command with busy transmitter
    b_tx = tx_cnt;
    tx_busy = 1'b1;
    send(8'h33);
    cyc(5);
    chk("bad_held", tx_cnt - b_tx, 0);
    chk("bad_err", err, 1);
    tx_busy = 1'b0;
    wait_tx("bad_tx_seen", b_tx);
    chk("bad_nak", tx_last, 8'h15);
    cyc(2);

    // byte dropped while response pending
    do_reset();
    b_tx = tx_cnt;
    tx_busy = 1'b1;
    send(8'h52); send(8'h30);
    chk("drop_err_pre", err, 0);
    send(8'h55);
    chk("drop_err", err, 1);
    tx_busy = 1'b0;
    wait_tx("drop_tx_seen", b_tx);
    chk("drop_data", tx_last, 8'h77);
    cyc(2);

    // halt commands
    do_reset();
    b_tx = tx_cnt;
    send(8'h48);
    wait_tx("h_tx_seen", b_tx);
`ifdef UP_MEM_CTRL_HALT_EN
    chk("h_ack", tx_last, 8'h06);
    chk("h_err", err, 0);
    cyc(2);
    cpu_req = 1'b1;
    #1 chk("h_gnt_off", cpu_gnt, 0);
    b_tx = tx_cnt;
    send(8'h47);
    wait_tx("g_tx_seen", b_tx);
    chk("g_ack", tx_last, 8'h06);
    #1 chk("g_gnt_on", cpu_gnt, 1);
    cpu_req = 1'b0;
`else
    chk("h_nak", tx_last, 8'h15);
    chk("h_err", err, 1);
    cyc(2);
    cpu_req = 1'b1;
    #1 chk("h_gnt_on", cpu_gnt, 1);
    cpu_req = 1'b0;
`endif
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
